// File: rtl/mp3_stream_allocator.sv
// Double-buffered SD-block to SPI-chunk allocator: a fill FSM loads ping-pong
// banks from the SD reader while a play FSM hands chunks to the MP3 sender.
module mp3_stream_allocator #(
  parameter  int CHUNK_W    = 256,
  parameter  int NUM_CHUNKS = 16,
  localparam int IDX_W      = $clog2(NUM_CHUNKS),
  localparam int BUF_W      = CHUNK_W * NUM_CHUNKS
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_sender_is_sending,
  input  logic               i_sd_is_reading,
  input  logic [BUF_W-1:0]   i_data_in,
  output logic [CHUNK_W-1:0] o_data_to_send,
  output logic               o_data_valid,
  output logic               o_need_new_data,
  output logic [IDX_W-1:0]   o_chunk_index,
  output logic               o_play_bank,
  output logic [15:0]        o_underrun_cnt
);

  typedef enum logic [2:0] {P_IDLE, P_STALL, P_OFFER, P_BUSY, P_NEXT} play_t;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_READ} fill_t;

  play_t r_play, w_play_nxt;
  fill_t r_fill, w_fill_nxt;
  logic [1:0]       r_full, w_full_nxt;
  logic             r_tgt;
  logic             r_dv;
  logic             r_need;
  logic [IDX_W-1:0] r_idx;
  logic             r_pb;
  logic [15:0]      r_ucnt;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] r_bank [2];

  logic w_last;
  logic w_next_bank;
  logic w_capture;
  logic w_underrun;

  assign w_last      = (r_idx == IDX_W'(NUM_CHUNKS - 1));
  assign w_next_bank = r_pb ^ w_last;
  assign w_capture   = (r_fill == F_READ) && !i_sd_is_reading && i_start;
  assign w_underrun  = (r_play == P_NEXT) && i_start && !r_full[w_next_bank];

  always_comb begin
    w_play_nxt = r_play;
    case (r_play)
      P_IDLE:  if (i_start) w_play_nxt = P_STALL;
      P_STALL: if (r_full[r_pb] && !i_pause) w_play_nxt = P_OFFER;
      P_OFFER: begin
        if (i_pause)                  w_play_nxt = P_STALL;
        else if (i_sender_is_sending) w_play_nxt = P_BUSY;
      end
      P_BUSY:  if (!i_sender_is_sending) w_play_nxt = P_NEXT;
      P_NEXT:  w_play_nxt = (r_full[w_next_bank] && !i_pause) ? P_OFFER : P_STALL;
      default: w_play_nxt = P_IDLE;
    endcase
    if (!i_start) w_play_nxt = P_IDLE;
  end

  always_comb begin
    w_fill_nxt = r_fill;
    case (r_fill)
      F_IDLE:  if (r_play != P_IDLE && r_full != 2'b11) w_fill_nxt = F_REQ;
      F_REQ:   if (i_sd_is_reading) w_fill_nxt = F_READ;
      F_READ:  if (!i_sd_is_reading) w_fill_nxt = F_IDLE;
      default: w_fill_nxt = F_IDLE;
    endcase
    if (!i_start) w_fill_nxt = F_IDLE;
  end

  // Capture and end-of-block clear always hit different banks, so both apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_capture) w_full_nxt[r_tgt] = 1'b1;
    if (r_play == P_NEXT && w_last) w_full_nxt[r_pb] = 1'b0;
    if (!i_start) w_full_nxt = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_play <= P_IDLE;
      r_fill <= F_IDLE;
      r_full <= '0;
      r_tgt  <= 1'b0;
      r_dv   <= 1'b0;
      r_need <= 1'b0;
      r_idx  <= '0;
      r_pb   <= 1'b0;
      r_ucnt <= '0;
    end else begin
      r_play <= w_play_nxt;
      r_fill <= w_fill_nxt;
      r_full <= w_full_nxt;
      r_dv   <= (w_play_nxt == P_OFFER);
      r_need <= (w_fill_nxt == F_REQ);
      // Refill the play bank first when it is empty so a cold start plays at once.
      if (r_fill == F_IDLE && w_fill_nxt == F_REQ)
        r_tgt <= r_full[r_pb] ? ~r_pb : r_pb;
      if (!i_start) begin
        r_idx <= '0;
        r_pb  <= 1'b0;
      end else if (r_play == P_NEXT) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) r_pb <= ~r_pb;
      end
      if (w_underrun && r_ucnt != '1) r_ucnt <= r_ucnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_capture) r_bank[r_tgt] <= i_data_in;
  end

  assign o_data_to_send  = r_bank[r_pb][r_idx];
  assign o_data_valid    = r_dv;
  assign o_need_new_data = r_need;
  assign o_chunk_index   = r_idx;
  assign o_play_bank     = r_pb;
  assign o_underrun_cnt  = r_ucnt;

endmodule

// File: tb/tb_mp3_stream_allocator.sv
// Directed bench for mp3_stream_allocator with 4 chunks of 8 bits: a cycle table
// for cold start into underrun, then hand sequences for pause, overlap, stop, reset.
module tb_mp3_stream_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, pause, snd, sd;
  logic [31:0] din;
  logic [7:0]  data_to_send;
  logic        dv, need, pb;
  logic [1:0]  idx;
  logic [15:0] ucnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mp3_stream_allocator #(.CHUNK_W(8), .NUM_CHUNKS(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause),
    .i_sender_is_sending(snd), .i_sd_is_reading(sd), .i_data_in(din),
    .o_data_to_send(data_to_send), .o_data_valid(dv), .o_need_new_data(need),
    .o_chunk_index(idx), .o_play_bank(pb), .o_underrun_cnt(ucnt)
  );

  typedef struct {
    logic        start, pause, snd, sd;
    logic        dv, need;
    logic [1:0]  idx;
    logic        pb;
    logic [15:0] ucnt;
    logic        chk_data;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(logic st, logic pa, logic sn, logic s, logic v, logic n,
                              logic [1:0] ix, logic b, logic [15:0] u, logic cd, logic [7:0] d);
    vec_t r;
    r.start = st; r.pause = pa; r.snd = sn; r.sd = s;
    r.dv = v; r.need = n; r.idx = ix; r.pb = b; r.ucnt = u; r.chk_data = cd; r.data = d;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic n, input logic [1:0] ix,
                          input logic b, input logic [15:0] u);
    check({tag, " valid"}, 32'(v ? dv : dv), 32'(v));
    check({tag, " need"}, 32'(need), 32'(n));
    check({tag, " index"}, 32'(idx), 32'(ix));
    check({tag, " bank"}, 32'(pb), 32'(b));
    check({tag, " underrun"}, 32'(ucnt), 32'(u));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input string tag, input logic [7:0] d, input logic [1:0] ix,
                            input logic b);
    check({tag, " offer valid"}, 32'(dv), 32'd1);
    check({tag, " offer data"}, 32'(data_to_send), 32'(d));
    check({tag, " offer index"}, 32'(idx), 32'(ix));
    check({tag, " offer bank"}, 32'(pb), 32'(b));
    snd = 1'b1;
    step();
    check({tag, " busy valid"}, 32'(dv), 32'd0);
    check({tag, " busy data"}, 32'(data_to_send), 32'(d));
    step();
    snd = 1'b0;
    step();
    step();
  endtask

  initial begin
    logic [31:0] blk;
    blk = 32'hDDCCBBAA;
    vecs[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[1] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    vecs[2] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[3] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[4] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[5] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      vecs[6 + 4*c] = mk(1, 0, 0, 0, 1, 1, 2'(c), 0, 0, 1, blk[c*8 +: 8]);
      vecs[7 + 4*c] = mk(1, 0, 1, 0, 0, 1, 2'(c), 0, 0, 1, blk[c*8 +: 8]);
      vecs[8 + 4*c] = mk(1, 0, 1, 0, 0, 1, 2'(c), 0, 0, 1, blk[c*8 +: 8]);
      vecs[9 + 4*c] = mk(1, 0, 0, 0, 0, 1, 2'(c), 0, 0, 1, blk[c*8 +: 8]);
    end
    vecs[22] = mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 8'h00);

    rst_n = 1'b0; start = 1'b0; pause = 1'b0; snd = 1'b0; sd = 1'b0; din = blk;
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_outs("idle", 0, 0, 0, 0, 0);

    // Cold start straight into an underrun at the end of the first block.
    for (int i = 0; i < 23; i++) begin
      start = vecs[i].start; pause = vecs[i].pause; snd = vecs[i].snd; sd = vecs[i].sd;
      step();
      chk_outs($sformatf("row%0d", i), vecs[i].dv, vecs[i].need, vecs[i].idx,
               vecs[i].pb, vecs[i].ucnt);
      if (vecs[i].chk_data)
        check($sformatf("row%0d data", i), 32'(data_to_send), 32'(vecs[i].data));
    end

    for (int i = 0; i < 50; i++) begin
      step();
      check($sformatf("stall%0d valid", i), 32'(dv), 32'd0);
    end
    sd = 1'b0; din = 32'h44332211;
    step();
    check("underrun capture valid", 32'(dv), 32'd0);
    step();
    chk_outs("underrun offer", 1, 1, 0, 1, 1);
    check("underrun offer data", 32'(data_to_send), 32'h11);

    pause = 1'b1;
    step();
    check("pause drop valid", 32'(dv), 32'd0);
    snd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("pause%0d valid", i), 32'(dv), 32'd0);
      check($sformatf("pause%0d index", i), 32'(idx), 32'd0);
    end
    snd = 1'b0;
    step();
    pause = 1'b0;
    step();
    chk_outs("pause release", 1, 1, 0, 1, 1);
    check("pause release data", 32'(data_to_send), 32'h11);

    // Refill bank 0 while bank 1 plays; the swap must not stall.
    sd = 1'b1;
    step();
    check("overlap read need", 32'(need), 32'd0);
    check("overlap read valid", 32'(dv), 32'd1);
    sd = 1'b0; din = 32'h88776655;
    step();
    send_chunk("b1c0", 8'h11, 2'd0, 1'b1);
    send_chunk("b1c1", 8'h22, 2'd1, 1'b1);
    send_chunk("b1c2", 8'h33, 2'd2, 1'b1);
    send_chunk("b1c3", 8'h44, 2'd3, 1'b1);
    chk_outs("swap", 1, 0, 0, 0, 1);
    check("swap data", 32'(data_to_send), 32'h55);
    step();
    check("swap refill need", 32'(need), 32'd1);

    sd = 1'b1;
    step();
    check("stop read need", 32'(need), 32'd0);
    start = 1'b0;
    step();
    chk_outs("stop", 0, 0, 0, 0, 1);
    sd = 1'b0; din = 32'hFFFFFFFF;
    step();
    chk_outs("stop discard", 0, 0, 0, 0, 1);
    start = 1'b1;
    step();
    chk_outs("restart", 0, 0, 0, 0, 1);
    step();
    chk_outs("restart req", 0, 1, 0, 0, 1);
    step();
    chk_outs("restart empty", 0, 1, 0, 0, 1);
    sd = 1'b1;
    step();
    check("restart read need", 32'(need), 32'd0);
    sd = 1'b0; din = 32'hA1B2C3D4;
    step();
    check("restart capture valid", 32'(dv), 32'd0);
    step();
    chk_outs("restart offer", 1, 1, 0, 0, 1);
    check("restart offer data", 32'(data_to_send), 32'hD4);

    send_chunk("rc0", 8'hD4, 2'd0, 1'b0);
    check("rc1 data", 32'(data_to_send), 32'hC3);
    snd = 1'b1;
    step();
    chk_outs("busy before reset", 0, 1, 1, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outs("async reset", 0, 0, 0, 0, 0);
    snd = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
